// File: rtl/lc3_mmio_pkg.sv
// Shared constants, mux encodings and access-FSM states for the LC-3 memory/I-O control stage.
package lc3_mmio_pkg;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  localparam logic [1:0] SEL_KBDR = 2'b00;
  localparam logic [1:0] SEL_KBSR = 2'b01;
  localparam logic [1:0] SEL_DSR  = 2'b10;
  localparam logic [1:0] SEL_MEM  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DEV,
    MEM_WAIT
  } state_e;

endpackage

// File: rtl/lc3_mmio_ctrl_if.sv
// Bus bundle between the control FSM / devices / memory and the MMIO control stage.
interface lc3_mmio_ctrl_if;
  logic [15:0] mar;
  logic        mio_en;
  logic        r_w;
  logic [15:0] mdr_in;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        disp_ack;
  logic [1:0]  inmux_sel;
  logic [15:0] kbdr_out;
  logic [15:0] kbsr_out;
  logic [15:0] dsr_out;
  logic        mem_en;
  logic        mem_we;
  logic        r;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        kb_int;
  logic        kb_drop;
  logic        ddr_drop;

  modport slave (
    input  mar, mio_en, r_w, mdr_in, kb_valid, kb_data, disp_ack,
    output inmux_sel, kbdr_out, kbsr_out, dsr_out, mem_en, mem_we, r,
           disp_valid, disp_data, kb_int, kb_drop, ddr_drop
  );

  modport master (
    output mar, mio_en, r_w, mdr_in, kb_valid, kb_data, disp_ack,
    input  inmux_sel, kbdr_out, kbsr_out, dsr_out, mem_en, mem_we, r,
           disp_valid, disp_data, kb_int, kb_drop, ddr_drop
  );
endinterface

// File: rtl/lc3_mmio_dev_regs.sv
// Keyboard/display device registers; side effects commit on the access completion edge.
module lc3_mmio_dev_regs #(
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_done,
  input  logic        i_r_w,
  input  logic [15:0] i_mar,
  input  logic        i_mdr_ie,
  input  logic [7:0]  i_mdr_char,
  input  logic        i_kb_valid,
  input  logic [7:0]  i_kb_data,
  input  logic        i_disp_ack,
  output logic [15:0] o_kbdr,
  output logic [15:0] o_kbsr,
  output logic [15:0] o_dsr,
  output logic        o_disp_valid,
  output logic [7:0]  o_disp_data,
  output logic        o_kb_int,
  output logic        o_kb_drop,
  output logic        o_ddr_drop
);

  logic [7:0] r_kbdr;
  logic       r_kb_ready;
  logic       r_kb_ie;
  logic       r_dsr_ready;
  logic       r_disp_valid;
  logic [7:0] r_disp_data;
  logic       r_kb_drop;
  logic       r_ddr_drop;

  logic w_kbdr_rd;
  logic w_kbsr_wr;
  logic w_ddr_wr;

  assign w_kbdr_rd = i_done & ~i_r_w & (i_mar == KBDR_ADDR);
  assign w_kbsr_wr = i_done &  i_r_w & (i_mar == KBSR_ADDR);
  assign w_ddr_wr  = i_done &  i_r_w & (i_mar == DDR_ADDR);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_kbdr       <= 8'h00;
      r_kb_ready   <= 1'b0;
      r_kb_ie      <= 1'b0;
      r_dsr_ready  <= 1'b1;
      r_disp_valid <= 1'b0;
      r_disp_data  <= 8'h00;
      r_kb_drop    <= 1'b0;
      r_ddr_drop   <= 1'b0;
    end else begin
      r_kb_drop  <= 1'b0;
      r_ddr_drop <= 1'b0;
      // A KBDR read freeing the slot on the same edge lets a new character in without a drop.
      if (i_kb_valid && (!r_kb_ready || w_kbdr_rd)) begin
        r_kbdr     <= i_kb_data;
        r_kb_ready <= 1'b1;
      end else if (i_kb_valid) begin
        r_kb_drop <= 1'b1;
      end else if (w_kbdr_rd) begin
        r_kb_ready <= 1'b0;
      end
      if (w_kbsr_wr) begin
        r_kb_ie <= i_mdr_ie;
      end
      if (r_disp_valid && i_disp_ack) begin
        r_disp_valid <= 1'b0;
        r_dsr_ready  <= 1'b1;
      end
      if (w_ddr_wr) begin
        if (r_dsr_ready) begin
          r_disp_data  <= i_mdr_char;
          r_disp_valid <= 1'b1;
          r_dsr_ready  <= 1'b0;
        end else begin
          r_ddr_drop <= 1'b1;
        end
      end
    end
  end

  assign o_kbdr       = {8'h00, r_kbdr};
  assign o_kbsr       = {r_kb_ready, r_kb_ie, 14'h0000};
  assign o_dsr        = {r_dsr_ready, 15'h0000};
  assign o_disp_valid = r_disp_valid;
  assign o_disp_data  = r_disp_data;
  assign o_kb_int     = r_kb_ready & r_kb_ie;
  assign o_kb_drop    = r_kb_drop;
  assign o_ddr_drop   = r_ddr_drop;

endmodule

// File: rtl/lc3_mmio_ctrl.sv
// MAR decode, device/memory access sequencing with latency counter, and R strobe generation.
module lc3_mmio_ctrl
  import lc3_mmio_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 3,
  parameter logic [15:0] KBSR_ADDR   = ADDR_KBSR,
  parameter logic [15:0] KBDR_ADDR   = ADDR_KBDR,
  parameter logic [15:0] DSR_ADDR    = ADDR_DSR,
  parameter logic [15:0] DDR_ADDR    = ADDR_DDR
) (
  input  logic           i_clk,
  input  logic           i_reset,
  lc3_mmio_ctrl_if.slave io_bus
);

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_e     r_state;
  state_e     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       w_is_dev;
  logic       w_r;
  logic       w_mem_en;
  logic       w_dev_done;
  logic [1:0] w_sel;

  assign w_is_dev = (io_bus.mar == KBSR_ADDR) || (io_bus.mar == KBDR_ADDR) ||
                    (io_bus.mar == DSR_ADDR)  || (io_bus.mar == DDR_ADDR);

  always_comb begin
    if (io_bus.mar == KBDR_ADDR)      w_sel = SEL_KBDR;
    else if (io_bus.mar == KBSR_ADDR) w_sel = SEL_KBSR;
    else if (io_bus.mar == DSR_ADDR)  w_sel = SEL_DSR;
    else                              w_sel = SEL_MEM;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_r          = 1'b0;
    w_mem_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_bus.mio_en) begin
          if (w_is_dev) begin
            w_state_next = DEV;
          end else begin
            w_state_next = MEM_WAIT;
            w_cnt_next   = 4'd1;
          end
        end
      end
      DEV: begin
        w_r          = 1'b1;
        w_state_next = IDLE;
      end
      MEM_WAIT: begin
        w_mem_en = 1'b1;
        if (r_cnt == LAT) begin
          w_r          = 1'b1;
          w_state_next = IDLE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // An access cut short by reset must not report completion.
    if (i_reset) w_r = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_dev_done = (r_state == DEV) & ~i_reset;

  assign io_bus.inmux_sel = w_sel;
  assign io_bus.r         = w_r;
  assign io_bus.mem_en    = w_mem_en;
  assign io_bus.mem_we    = w_mem_en & io_bus.r_w;

  lc3_mmio_dev_regs #(
    .KBSR_ADDR(KBSR_ADDR),
    .KBDR_ADDR(KBDR_ADDR),
    .DDR_ADDR (DDR_ADDR)
  ) u_dev_regs (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_done      (w_dev_done),
    .i_r_w       (io_bus.r_w),
    .i_mar       (io_bus.mar),
    .i_mdr_ie    (io_bus.mdr_in[14]),
    .i_mdr_char  (io_bus.mdr_in[7:0]),
    .i_kb_valid  (io_bus.kb_valid),
    .i_kb_data   (io_bus.kb_data),
    .i_disp_ack  (io_bus.disp_ack),
    .o_kbdr      (io_bus.kbdr_out),
    .o_kbsr      (io_bus.kbsr_out),
    .o_dsr       (io_bus.dsr_out),
    .o_disp_valid(io_bus.disp_valid),
    .o_disp_data (io_bus.disp_data),
    .o_kb_int    (io_bus.kb_int),
    .o_kb_drop   (io_bus.kb_drop),
    .o_ddr_drop  (io_bus.ddr_drop)
  );

endmodule

// File: doc/lc3_mmio_ctrl.md
Name: lc3_mmio_ctrl

Overview:
Memory/I-O address-control stage that sits directly upstream of the INMUX/MIOMUX pair. It decodes MAR and produces INMUX_SEL. It holds the KBSR, KBDR, DSR and DDR device registers and sequences memory accesses with a latency counter, returning the ready strobe R to the control FSM. It also provides a valid/ack handshake to the keyboard source and the display sink.

Parameters:
MEM_LATENCY, 3, cycles from memory-access start to R pulse; legal range 1..15
KBSR_ADDR, 16'hFE00, keyboard status address
KBDR_ADDR, 16'hFE02, keyboard data address
DSR_ADDR, 16'hFE04, display status address
DDR_ADDR, 16'hFE06, display data address

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
MAR  in  16  access address, held stable by control until R
MIO_EN  in  1  access request, held until R
R_W  in  1  1 = write, 0 = read
MDR_IN  in  16  write data (MDR contents)
KB_VALID  in  1  keyboard character strobe
KB_DATA  in  8  keyboard character
DISP_ACK  in  1  display consumed character
INMUX_SEL  out  2  00 KBDR, 01 KBSR, 10 DSR, 11 MEM
KBDR_OUT  out  16  {8'h00, KBDR}
KBSR_OUT  out  16  {ready, IE, 14'h0}
DSR_OUT  out  16  {ready, 15'h0}
MEM_EN  out  1  memory enable
MEM_WE  out  1  memory write enable
R  out  1  access complete, one-cycle pulse
DISP_VALID  out  1  DISP_DATA valid
DISP_DATA  out  8  character to display
KB_INT  out  1  KBSR[15] & KBSR[14]
KB_DROP  out  1  one-cycle pulse: character lost
DDR_DROP  out  1  one-cycle pulse: DDR write ignored

Behaviour:
- INMUX_SEL is combinational from MAR. KBDR_ADDR gives 00, KBSR_ADDR gives 01, DSR_ADDR gives 10, and any other address gives 11. "Device address" means the four parameter addresses.
- FSM states: IDLE, DEV, MEM_WAIT.
- IDLE, MIO_EN=1, device address: go to DEV. R=1 during the DEV cycle, then return to IDLE. Device latency is 1 cycle.
- IDLE, MIO_EN=1, other address: load counter = 1 and go to MEM_WAIT.
  - MEM_EN=1 throughout MEM_WAIT. MEM_WE = MEM_EN & R_W.
  - Counter increments each cycle. R=1 in the cycle where counter == MEM_LATENCY; the FSM then returns to IDLE.
  - Result: MEM_EN is high for exactly MEM_LATENCY cycles.
- R is a single-cycle pulse. If MIO_EN is high in IDLE on the following cycle, that is a new access (back-to-back allowed).
- Device side effects commit on the clock edge ending the R cycle ("completion").
- Keyboard path:
  - KB_VALID with KBSR[15]=0: KBDR <= KB_DATA and KBSR[15] <= 1.
  - KB_VALID with KBSR[15]=1: character discarded and KB_DROP pulses.
  - Read completion on KBDR_ADDR clears KBSR[15].
  - Read completion on KBDR plus KB_VALID on the same edge: new character loaded, KBSR[15] stays 1, no drop.
- KBSR write completion: KBSR[14] <= MDR_IN[14]; KBSR[15] is unaffected.
- Display path, DDR write completion with DSR[15]=1: DISP_DATA <= MDR_IN[7:0], DISP_VALID <= 1, DSR[15] <= 0.
- Display path, DDR write completion with DSR[15]=0: data not overwritten and DDR_DROP pulses.
- DISP_VALID stays high until DISP_ACK is sampled high. On that edge DISP_VALID <= 0 and DSR[15] <= 1. DISP_ACK while DISP_VALID=0 is ignored.
- Writes to KBDR and DSR are ignored but still complete with R. Device accesses never assert MEM_EN.
- Reset values:
  - FSM=IDLE, counter 0.
  - R, MEM_EN, MEM_WE, DISP_VALID, KB_DROP, DDR_DROP, KB_INT = 0.
  - KBDR=0, KBSR=0, DSR=16'h8000, DISP_DATA=0.
- Reset mid-access aborts it: no R, and MEM_EN drops the next cycle. Reset also abandons a pending display character.
- MIO_EN dropping mid-MEM_WAIT is a protocol violation. The access still completes with R.

Decomposition:
- Package lc3_mmio_pkg holds:
  - address constants;
  - INMUX_SEL encodings (SEL_KBDR, SEL_KBSR, SEL_DSR, SEL_MEM);
  - FSM state enum (IDLE, DEV, MEM_WAIT).
- Sub-module lc3_mmio_dev_regs holds KBSR/KBDR/DSR/DDR plus the keyboard and display handshakes. It is driven by completion strobes from the top-level access FSM and counter.

Test Plan:
- Memory read, MAR=16'h3000, MIO_EN held, MEM_LATENCY=3 -> INMUX_SEL=11, MEM_EN high for 3 cycles, MEM_WE=0, R pulses in the 3rd cycle only.
- KB_VALID with KB_DATA=8'h41, then read MAR=16'hFE00, then 16'hFE02 -> KBSR_OUT=16'h8000, INMUX_SEL=01 then 00, KBDR_OUT=16'h0041, R one cycle after MIO_EN each time. After the KBDR completion KBSR_OUT=16'h0000.
- Second KB_VALID (8'h42) before the KBDR read -> KB_DROP pulses and KBDR stays 16'h0041. Then KB_VALID (8'h43) on the KBDR read-completion edge -> KBDR=16'h0043 with KBSR[15]=1.
- Write MDR_IN=16'h0058 to 16'hFE06 -> DISP_DATA=8'h58, DISP_VALID=1, DSR_OUT=16'h0000. A second DDR write before ack -> DDR_DROP and DISP_DATA unchanged. DISP_ACK -> DISP_VALID=0, DSR_OUT=16'h8000.
- Write 16'h4000 to 16'hFE00 with KBSR[15]=1 -> KB_INT=1.
- RESET asserted in the 2nd MEM_WAIT cycle -> no R, MEM_EN=0 the next cycle, DSR_OUT=16'h8000, all strobes 0.
